// File: rtl/clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : clken_gen
// Brief    : NCH independent fractional clock-enable generators. Each channel
//            pulses ce[i] at an average rate of inc/mod of clk with the
//            remainder carried, so the pattern never drifts. An align strobe
//            restarts every channel from its phase; lock reports that nothing
//            has been disturbed for LOCK_CYCLES cycles.
//            Optional feature macro: CLKEN_DYNCFG_EN (runtime reconfiguration
//            port; without it inc/mod/phase are the *_INIT constants).
// Revision : 1.0  initial release
// ============================================================================
module clken_gen #(
    parameter int                   NCH         = 4,
    parameter int                   ACC_W       = 16,
    parameter logic [NCH*ACC_W-1:0] INC_INIT    = {NCH{16'd1}},
    parameter logic [NCH*ACC_W-1:0] MOD_INIT    = {NCH{16'd2}},
    parameter logic [NCH*ACC_W-1:0] PH_INIT     = {NCH{16'd0}},
    parameter int                   LOCK_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             align,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [ACC_W-1:0] cfg_mod,
    input  logic [ACC_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic [NCH-1:0]   ce,
    output logic             lock
);

    localparam logic [15:0] c_LOCK_MAX = 16'(LOCK_CYCLES);

    // Effective per-channel settings (registers or constants)
    logic [ACC_W-1:0] w_inc [NCH];
    logic [ACC_W-1:0] w_mod [NCH];
    logic [ACC_W-1:0] w_ph  [NCH];
    logic [NCH-1:0]   w_wr_en;
    logic             w_cfg_wr;

    logic [ACC_W-1:0] r_acc     [NCH];
    logic [ACC_W-1:0] w_acc_nxt [NCH];
    logic [NCH-1:0]   w_wrap;
    logic [NCH-1:0]   r_ce;
    logic [15:0]      r_lock_cnt;
    logic [15:0]      w_lock_cnt_nxt;
    logic             r_lock;

`ifdef CLKEN_DYNCFG_EN
    logic [ACC_W-1:0] r_inc [NCH];
    logic [ACC_W-1:0] r_mod [NCH];
    logic [ACC_W-1:0] r_ph  [NCH];
    logic             r_busy;
    logic             r_err;
    logic             w_accept;
    logic             w_cfg_ok;

    // Ready drops for the single cycle after any accepted request
    assign cfg_ready = resetn & ~r_busy;
    assign w_accept  = cfg_valid & cfg_ready;
    assign w_cfg_ok  = ({1'b0, cfg_ch} < 4'(NCH)) && (cfg_mod != '0)
                    && (cfg_inc <= cfg_mod) && (cfg_phase < cfg_mod);
    assign w_cfg_wr  = w_accept & w_cfg_ok;
    assign cfg_err   = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
                r_mod[i] <= MOD_INIT[i*ACC_W +: ACC_W];
                r_ph[i]  <= PH_INIT[i*ACC_W +: ACC_W];
            end
        end else begin
            r_busy <= w_accept;
            r_err  <= w_accept & ~w_cfg_ok;
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_en[i]) begin
                    r_inc[i] <= cfg_inc;
                    r_mod[i] <= cfg_mod;
                    r_ph[i]  <= cfg_phase;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cfg
        assign w_wr_en[i] = w_cfg_wr && (cfg_ch == 3'(i));
        assign w_inc[i]   = r_inc[i];
        assign w_mod[i]   = r_mod[i];
        assign w_ph[i]    = r_ph[i];
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{cfg_valid, cfg_ch, cfg_inc, cfg_mod, cfg_phase};
    assign cfg_ready    = 1'b0;
    assign cfg_err      = 1'b0;
    assign w_cfg_wr     = 1'b0;

    for (genvar i = 0; i < NCH; i++) begin : g_cfg
        assign w_wr_en[i] = 1'b0;
        assign w_inc[i]   = INC_INIT[i*ACC_W +: ACC_W];
        assign w_mod[i]   = MOD_INIT[i*ACC_W +: ACC_W];
        assign w_ph[i]    = PH_INIT[i*ACC_W +: ACC_W];
    end
`endif

    // One extra bit keeps acc + inc exact before the modulus compare
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [ACC_W:0] w_sum;
        logic [ACC_W:0] w_diff;

        assign w_sum        = {1'b0, r_acc[i]} + {1'b0, w_inc[i]};
        assign w_diff       = w_sum - {1'b0, w_mod[i]};
        assign w_wrap[i]    = (w_sum >= {1'b0, w_mod[i]});
        assign w_acc_nxt[i] = w_wrap[i] ? w_diff[ACC_W-1:0] : w_sum[ACC_W-1:0];
    end

    assign w_lock_cnt_nxt = (w_cfg_wr || align)          ? 16'd0      :
                            (r_lock_cnt == c_LOCK_MAX)   ? r_lock_cnt :
                                                           r_lock_cnt + 16'd1;

    // A channel being written takes the new phase even when align is high
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= PH_INIT[i*ACC_W +: ACC_W];
            end
            r_ce       <= '0;
            r_lock_cnt <= 16'd0;
            r_lock     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_en[i]) begin
                    r_acc[i] <= cfg_phase;
                    r_ce[i]  <= 1'b0;
                end else if (align) begin
                    r_acc[i] <= w_ph[i];
                    r_ce[i]  <= 1'b0;
                end else begin
                    r_acc[i] <= w_acc_nxt[i];
                    r_ce[i]  <= w_wrap[i];
                end
            end
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock     <= (w_lock_cnt_nxt == c_LOCK_MAX);
        end
    end

    assign ce   = r_ce;
    assign lock = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clken_gen
// Brief    : Directed self-checking bench for clken_gen (default 4 channels,
//            ACC_W=16, LOCK_CYCLES=64). Covers CLKEN_DYNCFG_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clken_gen;

    localparam int NCH   = 4;
    localparam int ACC_W = 16;

    logic             clk       = 1'b0;
    logic             resetn    = 1'b0;
    logic             align     = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [2:0]       cfg_ch    = '0;
    logic [ACC_W-1:0] cfg_inc   = '0;
    logic [ACC_W-1:0] cfg_mod   = '0;
    logic [ACC_W-1:0] cfg_phase = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic [NCH-1:0]   ce;
    logic             lock;

    always #5 clk = ~clk;

    clken_gen #(
        .NCH        (NCH),
        .ACC_W      (ACC_W),
        .LOCK_CYCLES(64)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .align    (align),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_mod  (cfg_mod),
        .cfg_phase(cfg_phase),
        .cfg_err  (cfg_err),
        .ce       (ce),
        .lock     (lock)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = -1;          // index of the last active edge since reset release
    int kind [NCH];          // expected pattern per channel
    int base [NCH];          // edge at which the channel restarted (ce forced 0)
    int lock_base = -1;      // edge at which the lock counter was last 0

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Hand-derived patterns, k = edges since restart:
    // 0: inc1/mod2 ph0 -> even k; 1: inc3/mod8 ph0 -> k%8 in {3,6,0};
    // 2: inc1/mod4 ph0 -> k%4==0; 3: inc1/mod4 ph2 -> k%4==2; 4: inc1/mod4 ph1 -> k%4==3
    function automatic logic exp_bit(input int kd, input int k);
        if (k <= 0) return 1'b0;
        case (kd)
            0:       return (k % 2) == 0;
            1:       return ((k % 8) == 3) || ((k % 8) == 6) || ((k % 8) == 0);
            2:       return (k % 4) == 0;
            3:       return (k % 4) == 2;
            default: return (k % 4) == 3;
        endcase
    endfunction

    task automatic cycle_chk(input string tag);
        logic [NCH-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) e[c] = exp_bit(kind[c], cyc - base[c]);
        check_eq({tag, "/ce"}, 32'(ce), 32'(e));
        check_eq({tag, "/lock"}, 32'(lock), 32'((cyc - lock_base) >= 64));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle_chk(tag);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            kind[c] = 0;
            base[c] = -1;
        end
        lock_base = -1;
        cyc       = -1;
    endtask

    task automatic restart_all();
        for (int c = 0; c < NCH; c++) base[c] = cyc + 1;
        lock_base = cyc + 1;
    endtask

    task automatic cfg_req(input int ch, input int inc, input int md, input int ph);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_mod   = ACC_W'(md);
        cfg_phase = ACC_W'(ph);
    endtask

`ifdef CLKEN_DYNCFG_EN
    localparam logic c_RDY = 1'b1;
`else
    localparam logic c_RDY = 1'b0;
`endif

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/ce", 32'(ce), 32'h0);
        check_eq("rst/lock", 32'(lock), 32'h0);
        check_eq("rst/cfg_ready", 32'(cfg_ready), 32'h0);
        check_eq("rst/cfg_err", 32'(cfg_err), 32'h0);

        resetn = 1'b1;
        #1;
        check_eq("rel/cfg_ready", 32'(cfg_ready), 32'(c_RDY));
        run(70, "por");

        align = 1'b1;
        restart_all();
        cycle_chk("align");
        align = 1'b0;
        run(66, "post_align");

`ifdef CLKEN_DYNCFG_EN
        // ch1 -> inc 3, mod 8, phase 0
        cfg_req(1, 3, 8, 0);
        kind[1] = 1; base[1] = cyc + 1; lock_base = cyc + 1;
        cycle_chk("wr_ch1");
        cfg_valid = 1'b0;
        check_eq("wr_ch1/ready", 32'(cfg_ready), 32'h0);
        check_eq("wr_ch1/err", 32'(cfg_err), 32'h0);
        cycle_chk("wr_ch1");
        check_eq("wr_ch1/ready_back", 32'(cfg_ready), 32'h1);
        run(64, "ch1_rate");

        // Rejected requests: modulus 0, then out-of-range channel
        cfg_req(0, 1, 0, 0);
        cycle_chk("rej_mod");
        cfg_valid = 1'b0;
        check_eq("rej_mod/err", 32'(cfg_err), 32'h1);
        check_eq("rej_mod/ready", 32'(cfg_ready), 32'h0);
        cycle_chk("rej_mod");
        check_eq("rej_mod/err_end", 32'(cfg_err), 32'h0);
        check_eq("rej_mod/ready_back", 32'(cfg_ready), 32'h1);

        cfg_req(5, 1, 2, 0);
        cycle_chk("rej_ch");
        cfg_valid = 1'b0;
        check_eq("rej_ch/err", 32'(cfg_err), 32'h1);
        check_eq("rej_ch/ready", 32'(cfg_ready), 32'h0);
        cycle_chk("rej_ch");
        check_eq("rej_ch/err_end", 32'(cfg_err), 32'h0);
        run(6, "rej_after");

        // ch0 and ch2 at inc 1 / mod 4 with phases 0 and 2, then align
        cfg_req(0, 1, 4, 0);
        kind[0] = 2; base[0] = cyc + 1; lock_base = cyc + 1;
        cycle_chk("wr_ch0");
        cfg_valid = 1'b0;
        cycle_chk("wr_gap");
        cfg_req(2, 1, 4, 2);
        kind[2] = 3; base[2] = cyc + 1; lock_base = cyc + 1;
        cycle_chk("wr_ch2");
        cfg_valid = 1'b0;
        check_eq("wr_ch2/err", 32'(cfg_err), 32'h0);
        run(5, "pre_align");
        align = 1'b1;
        restart_all();
        cycle_chk("align2");
        align = 1'b0;
        run(16, "phase_pat");

        // align together with a write to ch3 (phase 1)
        align = 1'b1;
        cfg_req(3, 1, 4, 1);
        kind[3] = 4;
        restart_all();
        cycle_chk("align_wr");
        align     = 1'b0;
        cfg_valid = 1'b0;
        run(66, "align_wr_run");
`else
        // Configuration port is inert: nothing accepted, nothing changes
        cfg_req(1, 3, 8, 0);
        cycle_chk("cfg_ignored");
        check_eq("cfg_ignored/ready", 32'(cfg_ready), 32'h0);
        check_eq("cfg_ignored/err", 32'(cfg_err), 32'h0);
        cfg_valid = 1'b0;
        run(8, "cfg_ignored_run");
`endif

        // One-cycle reset mid-pattern
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst/ce", 32'(ce), 32'h0);
        check_eq("mid_rst/lock", 32'(lock), 32'h0);
        check_eq("mid_rst/cfg_ready", 32'(cfg_ready), 32'h0);
        check_eq("mid_rst/cfg_err", 32'(cfg_err), 32'h0);
        resetn = 1'b1;
        model_reset();
        run(70, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
